// File: rtl/crypto_seq_pkg.sv
// Shared definitions for the crypto instruction sequencer: opcodes, FSM states,
// status bit positions and instruction field positions.
package crypto_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD_KEY = 2'b01,
    OP_RUN      = 2'b10,
    OP_CLEAR    = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    START = 2'b10,
    WAIT  = 2'b11
  } state_e;

  localparam int ST_ERROR        = 0;
  localparam int ST_KEY_LOADED   = 1;
  localparam int ST_RESULT_VALID = 2;
  localparam int ST_TIMEOUT      = 3;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 30;
  localparam int CNT_MSB = 3;
  localparam int CNT_LSB = 0;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 0;

  function automatic opcode_e decode_opcode(input logic [31:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-state watchdog: counts cycles while run is high, clears otherwise, and
// flags expiry on the LIMIT-th consecutive running cycle.
module seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || !run) count <= '0;
    else               count <= count + CW'(1);
  end

  assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/crypto_instr_sequencer.sv
// Instruction front-end for the crypto core: key streaming, op launch, result capture.
// Define SEQ_TIMEOUT_EN to add the WAIT-state watchdog (status[3] reports expiry).
module crypto_instr_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int KEY_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  instruct,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [31:0]                  keyInput,
  output logic                         key_wr_en,
  output logic [$clog2(KEY_WORDS)-1:0] key_wr_addr,
  output logic [31:0]                  key_wr_data,
  output logic                         core_start,
  output logic [7:0]                   core_op,
  input  logic                         core_done,
  input  logic [31:0]                  core_result,
  output logic [31:0]                  out,
  output logic [3:0]                   status
);

  localparam int         AW      = $clog2(KEY_WORDS);
  localparam logic [4:0] MAX_LEN = 5'(KEY_WORDS);

  state_e      state, next_state;
  opcode_e     opcode;
  logic        accept, len_ok, load_last, wd_expired;
  logic [4:0]  req_len, load_len, word_cnt, load_len_d, word_cnt_d;
  logic        key_wr_en_d, core_start_d;
  logic [AW-1:0] key_wr_addr_d;
  logic [31:0] key_wr_data_d, out_d;
  logic [7:0]  core_op_d;
  logic        error_q, key_loaded_q, result_valid_q, timeout_q;
  logic        error_d, key_loaded_d, result_valid_d;
  logic        unused_instr_bits;

  assign instr_ready       = (state == IDLE);
  assign accept            = instr_valid && instr_ready;
  assign opcode            = decode_opcode(instruct);
  assign req_len           = {1'b0, instruct[CNT_MSB:CNT_LSB]};
  assign len_ok            = (req_len != 5'd0) && (req_len <= MAX_LEN);
  assign load_last         = (word_cnt == load_len - 5'd1);
  assign unused_instr_bits = ^instruct[OPC_LSB-1:OP_MSB+1];

`ifdef SEQ_TIMEOUT_EN
  logic timeout_d;

  seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .run     (state == WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
  assign timeout_q  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      load_len       <= '0;
      word_cnt       <= '0;
      key_wr_en      <= 1'b0;
      key_wr_addr    <= '0;
      key_wr_data    <= '0;
      core_start     <= 1'b0;
      core_op        <= '0;
      out            <= '0;
      error_q        <= 1'b0;
      key_loaded_q   <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      state          <= next_state;
      load_len       <= load_len_d;
      word_cnt       <= word_cnt_d;
      key_wr_en      <= key_wr_en_d;
      key_wr_addr    <= key_wr_addr_d;
      key_wr_data    <= key_wr_data_d;
      core_start     <= core_start_d;
      core_op        <= core_op_d;
      out            <= out_d;
      error_q        <= error_d;
      key_loaded_q   <= key_loaded_d;
      result_valid_q <= result_valid_d;
`ifdef SEQ_TIMEOUT_EN
      timeout_q      <= timeout_d;
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && opcode == OP_LOAD_KEY && len_ok)      next_state = LOAD;
        else if (accept && opcode == OP_RUN && key_loaded_q) next_state = START;
      end
      LOAD:    if (load_last) next_state = IDLE;
      START:   next_state = WAIT;
      WAIT:    if (core_done || wd_expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every output of this block is given a default first, so no path infers a latch.
  always_comb begin
    load_len_d     = load_len;
    word_cnt_d     = word_cnt;
    key_wr_en_d    = 1'b0;
    key_wr_addr_d  = key_wr_addr;
    key_wr_data_d  = key_wr_data;
    core_start_d   = 1'b0;
    core_op_d      = core_op;
    out_d          = out;
    error_d        = error_q;
    key_loaded_d   = key_loaded_q;
    result_valid_d = result_valid_q;
`ifdef SEQ_TIMEOUT_EN
    timeout_d      = timeout_q;
`endif
    case (state)
      IDLE: if (accept) begin
        case (opcode)
          OP_LOAD_KEY: begin
            if (len_ok) begin
              load_len_d   = req_len;
              word_cnt_d   = '0;
              key_loaded_d = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end
          OP_RUN: begin
            if (key_loaded_q) begin
              core_op_d      = instruct[OP_MSB:OP_LSB];
              result_valid_d = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end
          OP_CLEAR: begin
            error_d        = 1'b0;
            key_loaded_d   = 1'b0;
            result_valid_d = 1'b0;
            out_d          = '0;
`ifdef SEQ_TIMEOUT_EN
            timeout_d      = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      LOAD: begin
        key_wr_en_d   = 1'b1;
        key_wr_addr_d = word_cnt[AW-1:0];
        key_wr_data_d = keyInput;
        word_cnt_d    = word_cnt + 5'd1;
        if (load_last) key_loaded_d = 1'b1;
      end
      START: core_start_d = 1'b1;
      WAIT: begin
        // A done on the expiry cycle counts as a normal completion.
        if (core_done) begin
          out_d          = core_result;
          result_valid_d = 1'b1;
        end else if (wd_expired) begin
          error_d = 1'b1;
`ifdef SEQ_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign status = {timeout_q, result_valid_q, key_loaded_q, error_q};

endmodule

// File: tb/tb_crypto_instr_sequencer.sv
// Directed self-checking bench for crypto_instr_sequencer (KEY_WORDS=4, TIMEOUT_CYCLES=16).
module tb_crypto_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruct = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] keyInput = '0;
  logic        key_wr_en;
  logic [1:0]  key_wr_addr;
  logic [31:0] key_wr_data;
  logic        core_start;
  logic [7:0]  core_op;
  logic        core_done = 1'b0;
  logic [31:0] core_result = '0;
  logic [31:0] out;
  logic [3:0]  status;

  int passed = 0;
  int total = 0;
  int wr_count = 0;
  int wr_base;

  crypto_instr_sequencer #(.KEY_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruct    (instruct),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .keyInput    (keyInput),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .core_start  (core_start),
    .core_op     (core_op),
    .core_done   (core_done),
    .core_result (core_result),
    .out         (out),
    .status      (status)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (key_wr_en === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] word);
    instruct    = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instruct    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_ready", instr_ready, 1);
    check("rst_wr_en", key_wr_en, 0);
    check("rst_addr", key_wr_addr, 0);
    check("rst_data", key_wr_data, 0);
    check("rst_start", core_start, 0);
    check("rst_op", core_op, 0);
    check("rst_out", out, 0);
    check("rst_status", status, 0);
    reset = 1'b0;

    // RUN without a key: error, no launch; CLEAR recovers
    issue(32'h8000_0084);
    check("nokey_status", status, 4'h1);
    check("nokey_ready", instr_ready, 1);
    tick(2);
    check("nokey_start", core_start, 0);
    issue(32'hC000_0000);
    check("clear_status", status, 4'h0);
    check("clear_out", out, 0);

    // Illegal load counts
    issue(32'h4000_0000);
    check("cnt0_status", status, 4'h1);
    check("cnt0_ready", instr_ready, 1);
    tick();
    check("cnt0_wr_en", key_wr_en, 0);
    issue(32'hC000_0000);
    issue(32'h4000_0005);
    check("cnt5_status", status, 4'h1);
    check("cnt5_ready", instr_ready, 1);
    tick();
    check("cnt5_wr_en", key_wr_en, 0);
    issue(32'hC000_0000);
    check("clear2_status", status, 4'h0);

    // Three-word key load
    wr_base = wr_count;
    instruct = 32'h4000_0003;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instruct = '0;
    keyInput = 32'h0000_00A0;
    check("load_ready0", instr_ready, 0);
    check("load_wr_en0", key_wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("load_wr_en", key_wr_en, 1);
      check("load_addr", key_wr_addr, i);
      check("load_data", key_wr_data, 32'hA0 + i);
      check("load_ready", instr_ready, (i == 2) ? 1 : 0);
      keyInput = 32'hA1 + i;
    end
    check("load_status", status, 4'h2);
    tick();
    check("load_wr_off", key_wr_en, 0);
    check("load_wr_count", wr_count - wr_base, 3);

    // RUN with completion
    issue(32'h8000_0084);
    check("run_op", core_op, 8'h84);
    check("run_start0", core_start, 0);
    check("run_ready", instr_ready, 0);
    tick();
    check("run_start1", core_start, 1);
    tick();
    check("run_start2", core_start, 0);
    tick(2);
    check("run_wait_ready", instr_ready, 0);
    check("run_wait_start", core_start, 0);
    core_done = 1'b1;
    core_result = 32'hDEAD_BEEF;
    tick();
    core_done = 1'b0;
    core_result = '0;
    check("run_out", out, 32'hDEAD_BEEF);
    check("run_status", status, 4'h6);
    check("run_ready_done", instr_ready, 1);
    check("run_op_hold", core_op, 8'h84);

    // RUN with no completion: timeout or indefinite wait
    issue(32'h8000_0011);
    tick(16);
    check("wait16_ready", instr_ready, 0);
    check("wait16_status", status, 4'h2);
    tick();
`ifdef SEQ_TIMEOUT_EN
    check("to_ready", instr_ready, 1);
    check("to_status", status, 4'hB);
    check("to_out", out, 32'hDEAD_BEEF);
    core_done = 1'b1;
    core_result = 32'h1111_1111;
    tick();
    core_done = 1'b0;
    core_result = '0;
    check("to_stray_out", out, 32'hDEAD_BEEF);
    check("to_stray_status", status, 4'hB);
`else
    check("nto_ready", instr_ready, 0);
    check("nto_status", status, 4'h2);
    check("nto_out", out, 32'hDEAD_BEEF);
    tick(10);
    check("nto_ready_late", instr_ready, 0);
    core_done = 1'b1;
    core_result = 32'h1234_5678;
    tick();
    core_done = 1'b0;
    core_result = '0;
    check("nto_out_done", out, 32'h1234_5678);
    check("nto_status_done", status, 4'h6);
    check("nto_ready_done", instr_ready, 1);
`endif
    issue(32'hC000_0000);
    check("clear3_status", status, 4'h0);
    check("clear3_out", out, 0);

    // Reset on the second LOAD cycle
    issue(32'h4000_0002);
    wr_base = wr_count;
    keyInput = 32'h0000_00B0;
    tick();
    check("rl_wr_en", key_wr_en, 1);
    check("rl_data", key_wr_data, 32'hB0);
    reset = 1'b1;
    keyInput = 32'h0000_00B1;
    tick();
    reset = 1'b0;
    check("rl_wr_off", key_wr_en, 0);
    check("rl_addr", key_wr_addr, 0);
    check("rl_data0", key_wr_data, 0);
    check("rl_start", core_start, 0);
    check("rl_op", core_op, 0);
    check("rl_out", out, 0);
    check("rl_status", status, 0);
    check("rl_ready", instr_ready, 1);
    tick();
    check("rl_wr_count", wr_count - wr_base, 1);

    // Stray core_done while IDLE
    core_done = 1'b1;
    core_result = 32'h5555_5555;
    tick();
    core_done = 1'b0;
    core_result = '0;
    check("stray_out", out, 0);
    check("stray_status", status, 0);
    check("stray_ready", instr_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
